control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//   Main instruction decoder of the i16 core. Maps the 3-bit major opcode to
//   datapath control strobes: ALU operation select, immediate-operand select,
//   upper-immediate load and flag-update enable. Sits between fetch and the
//   ALU/register-file write path. All outputs are registered.
// PARAMETERS (positional order fixed: L, OP_L, ALU_OP_WIDTH)
//   L             5  datapath field width; carried for interface compatibility, no logic uses it
//   OP_L          3  Opcode width; decode is defined for 3, upper bits ignored if wider
//   ALU_OP_WIDTH  2  ALUOpcode width; encodings below fit in 2 bits, zero-extend if wider
// PORTS
//   Clock               in   1             rising-edge clock
//   nReset              in   1             asynchronous, active-low reset
//   Opcode              in   OP_L          major opcode of current instruction
//   LoadUpperImmediate  out  1             write immediate into upper half of rd
//   ALUOpcode           out  ALU_OP_WIDTH  00 ADD, 01 SUB, 10 MUL, 11 DIV
//   UseImmediate        out  1             ALU operand B = immediate (else rs2)
//   UpdateFlags         out  1             ALU result updates status flags
// BEHAVIOUR
//   - Decode table (Opcode -> LUI, ALUOpcode, UseImm, UpdFlags):
//       000 DIV  -> 0,11,0,1    001 MULI -> 0,10,1,1    010 DIVI -> 0,11,1,1
//       011 LUI  -> 1,00,1,0    100 ADD  -> 0,00,0,1    101 SUB  -> 0,01,0,1
//       110 reserved -> 0,00,0,0 (NOP)                  111 MUL  -> 0,10,0,1
//   - Decode is combinational into output registers; outputs valid one Clock
//     edge after Opcode is sampled (latency 1 cycle); new opcode every cycle.
//   - nReset low: all outputs 0 immediately (async), held while low; first
//     decode occurs on the first rising edge after nReset deasserts.
//   - Reset mid-operation discards the in-flight decode; no partial state.
//   - X/Z on Opcode: outputs follow the reserved (NOP) row, never X.
//   - No other state; no handshake.
// CONFIGURATION
//   - Macro CONTROL_UNIT_ILLEGAL_TRAP_EN:
//     defined  -> extra port IllegalOpcode (out, 1), registered, reset 0,
//                 1 for exactly the cycles whose decoded Opcode is 110 (or X);
//                 other outputs still follow the NOP row.
//     undefined-> port absent; 110 silently decodes as NOP.
// STRUCTURE
//   - Shared package control_unit_pkg: opcode localparams (OP_DIV..OP_MUL),
//     ALU op localparams (ALU_ADD/SUB/MUL/DIV), packed control-word struct.
//   - One sub-module: control_unit_decode (pure combinational table lookup);
//     top holds only the output registers and the reset logic.
// TESTING
//   - Reset: nReset=0 with Opcode=111 -> all outputs 0; after release, one edge -> MUL row.
//   - Opcode 111 -> LUI=0 ALUOpcode=2 UseImm=0 UpdFlags=1; 000 -> 0,3,0,1.
//   - Opcode 001 -> 0,2,1,1; 010 -> 0,3,1,1; 011 -> 1,0,1,0.
//   - Opcode 100 -> 0,0,0,1; 101 -> 0,1,0,1; back-to-back change each cycle, 1-cycle lag.
//   - Opcode 110 -> all 0; with CONTROL_UNIT_ILLEGAL_TRAP_EN IllegalOpcode=1 for that cycle only.
//   - nReset pulsed low mid-stream with Opcode=011 -> outputs drop to 0 without a Clock edge.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the i16 main instruction decoder: major opcode
// encodings, ALU operation encodings and the packed control word that the
// decoder produces and the top-level registers.
// Optional feature macro: CONTROL_UNIT_ILLEGAL_TRAP_EN adds an illegal-opcode
// flag to the control word.
package control_unit_pkg;

  localparam logic [2:0] OP_DIV  = 3'b000;
  localparam logic [2:0] OP_MULI = 3'b001;
  localparam logic [2:0] OP_DIVI = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_RSVD = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef struct packed {
    logic       lui;
    logic [1:0] alu_op;
    logic       use_imm;
    logic       upd_flags;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_word_t;

  // All strobes low: the reserved opcode, unknown opcodes and reset all map here.
  localparam ctrl_word_t CTRL_NOP = '0;

  // Builds a legal control word; the illegal flag (when present) stays clear.
  function automatic ctrl_word_t make_ctrl(input logic lui, input logic [1:0] alu_op,
                                           input logic use_imm, input logic upd_flags);
    ctrl_word_t w;
    w           = CTRL_NOP;
    w.lui       = lui;
    w.alu_op    = alu_op;
    w.use_imm   = use_imm;
    w.upd_flags = upd_flags;
    return w;
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Pure combinational opcode-to-control-word table for the i16 decoder.
// Only the low three opcode bits take part in decode. Any opcode that does not
// match a legal row (reserved 110, or unknown bits) falls to the NOP row.
// Optional feature macro: CONTROL_UNIT_ILLEGAL_TRAP_EN flags those NOP cases.
import control_unit_pkg::*;

module control_unit_decode #(
  parameter int OP_L = 3
) (
  input  logic [OP_L-1:0] opcode,
  output ctrl_word_t      ctrl
);

  logic [2:0] op3;

  assign op3 = 3'(opcode);

  // Table lookup; the NOP default keeps unknown opcodes from producing X strobes.
  always_comb begin
    ctrl = CTRL_NOP;
    case (op3)
      OP_DIV:  ctrl = make_ctrl(1'b0, ALU_DIV, 1'b0, 1'b1);
      OP_MULI: ctrl = make_ctrl(1'b0, ALU_MUL, 1'b1, 1'b1);
      OP_DIVI: ctrl = make_ctrl(1'b0, ALU_DIV, 1'b1, 1'b1);
      OP_LUI:  ctrl = make_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0);
      OP_ADD:  ctrl = make_ctrl(1'b0, ALU_ADD, 1'b0, 1'b1);
      OP_SUB:  ctrl = make_ctrl(1'b0, ALU_SUB, 1'b0, 1'b1);
      OP_MUL:  ctrl = make_ctrl(1'b0, ALU_MUL, 1'b0, 1'b1);
      OP_RSVD: begin
        ctrl = CTRL_NOP;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        ctrl.illegal = 1'b1;
`endif
      end
      default: begin
        ctrl = CTRL_NOP;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        ctrl.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder of the i16 core. The combinational table lives in
// control_unit_decode; this level only registers its result so every control
// strobe appears one Clock edge after the opcode is sampled.
// Optional feature macro: CONTROL_UNIT_ILLEGAL_TRAP_EN adds the registered
// IllegalOpcode output, high for cycles whose decoded opcode was reserved.
import control_unit_pkg::*;

module control_unit #(
  parameter int L            = 5,
  parameter int OP_L         = 3,
  parameter int ALU_OP_WIDTH = 2
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [OP_L-1:0]         Opcode,
  output logic                    LoadUpperImmediate,
  output logic [ALU_OP_WIDTH-1:0] ALUOpcode,
  output logic                    UseImmediate,
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  output logic                    UpdateFlags,
  output logic                    IllegalOpcode
`else
  output logic                    UpdateFlags
`endif
);

  ctrl_word_t ctrl_d;
  ctrl_word_t ctrl_q;

  // L is a datapath width kept only so the port/parameter list matches the
  // rest of the core; nothing in the decoder depends on it.
  if (L < 1) begin : g_datapath_width_unused
  end

  control_unit_decode #(
    .OP_L (OP_L)
  ) u_decode (
    .opcode (Opcode),
    .ctrl   (ctrl_d)
  );

  // Output register; asynchronous reset clears every strobe, discarding any
  // decode that was about to be captured.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign LoadUpperImmediate = ctrl_q.lui;
  assign ALUOpcode          = ALU_OP_WIDTH'(ctrl_q.alu_op);
  assign UseImmediate       = ctrl_q.use_imm;
  assign UpdateFlags        = ctrl_q.upd_flags;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  assign IllegalOpcode      = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard testbench for control_unit. Stimulus pushes the hand-computed
// control word expected after each Clock edge (or after an asynchronous reset
// event); a separate monitor pops and compares on the falling edge.
// Optional feature macro: CONTROL_UNIT_ILLEGAL_TRAP_EN also checks IllegalOpcode.
module tb_control_unit;

  typedef struct packed {
    logic       lui;
    logic [1:0] alu;
    logic       imm;
    logic       upd;
    logic       ill;
  } exp_t;

  logic       Clock;
  logic       nReset;
  logic [2:0] Opcode;
  logic       LoadUpperImmediate;
  logic [1:0] ALUOpcode;
  logic       UseImmediate;
  logic       UpdateFlags;
  logic       illegal_obs;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  event sample_ev;

  control_unit #(
    .L            (5),
    .OP_L         (3),
    .ALU_OP_WIDTH (2)
  ) dut (
    .Clock              (Clock),
    .nReset             (nReset),
    .Opcode             (Opcode),
    .LoadUpperImmediate (LoadUpperImmediate),
    .ALUOpcode          (ALUOpcode),
    .UseImmediate       (UseImmediate),
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    .UpdateFlags        (UpdateFlags),
    .IllegalOpcode      (illegal_obs)
`else
    .UpdateFlags        (UpdateFlags)
`endif
  );

`ifndef CONTROL_UNIT_ILLEGAL_TRAP_EN
  assign illegal_obs = 1'b0;
`endif

  // Free-running clock, 10 time units per period.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic lui, input logic [1:0] alu,
                              input logic imm, input logic upd, input logic ill);
    exp_t e;
    e.lui = lui;
    e.alu = alu;
    e.imm = imm;
    e.upd = upd;
    e.ill = ill;
    return e;
  endfunction

  // Compares the current DUT outputs against one expected control word.
  task automatic checkOutput(input exp_t e);
    exp_t act;
    act = mk(LoadUpperImmediate, ALUOpcode, UseImmediate, UpdateFlags, illegal_obs);
`ifndef CONTROL_UNIT_ILLEGAL_TRAP_EN
    act.ill = e.ill;
`endif
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL ctrl_word t=%0t actual lui=%b alu=%b imm=%b upd=%b ill=%b required lui=%b alu=%b imm=%b upd=%b ill=%b",
               $time, act.lui, act.alu, act.imm, act.upd, act.ill,
               e.lui, e.alu, e.imm, e.upd, e.ill);
    end
  endtask

  // Drives one opcode ahead of the next rising edge, records what the outputs
  // must show after that edge, and returns on the following falling edge.
  task automatic applyStimulus(input logic [2:0] op, input exp_t e);
    Opcode = op;
    @(posedge Clock);
    exp_q.push_back(e);
    @(negedge Clock);
  endtask

  // Monitor: checks on every falling edge, or on demand for async events.
  always begin
    @(negedge Clock or sample_ev);
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    nReset = 1'b0;
    Opcode = 3'b111;

    // Reset held with a legal opcode present: outputs must stay cleared.
    #23;
    exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    ->sample_ev;
    @(negedge Clock);
    nReset = 1'b1;

    // First edge after release decodes MUL; then one new opcode per cycle.
    applyStimulus(3'b111, mk(1'b0, 2'd2, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b000, mk(1'b0, 2'd3, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b001, mk(1'b0, 2'd2, 1'b1, 1'b1, 1'b0));
    applyStimulus(3'b010, mk(1'b0, 2'd3, 1'b1, 1'b1, 1'b0));
    applyStimulus(3'b011, mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b0));
    applyStimulus(3'b100, mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b101, mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b110, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
    applyStimulus(3'b111, mk(1'b0, 2'd2, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b110, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
    applyStimulus(3'b101, mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b011, mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b0));

    // Asynchronous reset between edges while LUI is showing.
    #2;
    nReset = 1'b0;
    #1;
    exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    ->sample_ev;

    // Still held through a rising edge with LUI on the input.
    applyStimulus(3'b011, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    nReset = 1'b1;
    applyStimulus(3'b100, mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
    applyStimulus(3'b000, mk(1'b0, 2'd3, 1'b0, 1'b1, 1'b0));

    // Every expectation must have been consumed by the monitor.
    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
